// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the 2-read/1-write register file.
package regfile_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 8;
  localparam int RF_ADDR  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clr_ctrl.sv
// Clear-sweep controller: zeroes one entry per cycle, index 0 upward, while Busy is high.
module regfile_clr_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int ADDR  = RF_ADDR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_req,
  output logic            busy,
  output logic [ADDR-1:0] sweep_addr,
  output logic            sweep_we
);

  localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);

  clr_state_e      state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A request seen while already sweeping is dropped; the sweep runs to completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy       = (state_q == CLEAR);
  assign sweep_we   = busy;
  assign sweep_addr = cnt_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with write-to-read bypass and a clear sweep.
// Optional per-entry even parity with error injection under REGFILE_PARITY_EN.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int ADDR  = RF_ADDR
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WrEn,
  input  logic [ADDR-1:0]  WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic             RdEnA,
  input  logic [ADDR-1:0]  RdAddrA,
  output logic [WIDTH-1:0] RdDataA,
  output logic             RdValidA,
  input  logic             RdEnB,
  input  logic [ADDR-1:0]  RdAddrB,
  output logic [WIDTH-1:0] RdDataB,
  output logic             RdValidB,
  input  logic             ClrReq,
  output logic             Busy
`ifdef REGFILE_PARITY_EN
  ,
  input  logic             ParInj,
  output logic             ParErrA,
  output logic             ParErrB
`endif
);

  localparam logic [ADDR:0] DEPTH_X = (ADDR + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic             rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;
  logic             busy;
  logic [ADDR-1:0]  sweep_addr;
  logic             sweep_we;
  logic             wr_ok;

  regfile_clr_ctrl #(.DEPTH(DEPTH), .ADDR(ADDR)) u_clr_ctrl (
    .clk       (CLK),
    .rst       (RST),
    .clr_req   (ClrReq),
    .busy      (busy),
    .sweep_addr(sweep_addr),
    .sweep_we  (sweep_we)
  );

  assign wr_ok = WrEn && !busy && ({1'b0, WrAddr} < DEPTH_X);

`ifdef REGFILE_PARITY_EN
  logic par_q [DEPTH];
  logic par_d [DEPTH];
  logic par_err_a_q, par_err_a_d, par_err_b_q, par_err_b_d;
`endif

  // Out-of-range read addresses match no entry and wr_ok is never set for them, so they yield zero.
  always_comb begin
    rd_data_a_d  = rd_data_a_q;
    rd_data_b_d  = rd_data_b_q;
    rd_valid_a_d = 1'b0;
    rd_valid_b_d = 1'b0;
`ifdef REGFILE_PARITY_EN
    par_err_a_d  = 1'b0;
    par_err_b_d  = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
`ifdef REGFILE_PARITY_EN
      par_d[i] = par_q[i];
`endif
      if (sweep_we && (sweep_addr == ADDR'(i))) begin
        mem_d[i] = '0;
`ifdef REGFILE_PARITY_EN
        par_d[i] = 1'b0;
`endif
      end else if (wr_ok && (WrAddr == ADDR'(i))) begin
        mem_d[i] = WrData;
`ifdef REGFILE_PARITY_EN
        par_d[i] = (^WrData) ^ ParInj;
`endif
      end
    end
    if (RdEnA && !busy) begin
      rd_valid_a_d = 1'b1;
      rd_data_a_d  = '0;
      if (wr_ok && (WrAddr == RdAddrA)) begin
        rd_data_a_d = WrData;
`ifdef REGFILE_PARITY_EN
        par_err_a_d = ParInj;
`endif
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (RdAddrA == ADDR'(i)) begin
            rd_data_a_d = mem_q[i];
`ifdef REGFILE_PARITY_EN
            par_err_a_d = par_q[i] ^ (^mem_q[i]);
`endif
          end
        end
      end
    end
    if (RdEnB && !busy) begin
      rd_valid_b_d = 1'b1;
      rd_data_b_d  = '0;
      if (wr_ok && (WrAddr == RdAddrB)) begin
        rd_data_b_d = WrData;
`ifdef REGFILE_PARITY_EN
        par_err_b_d = ParInj;
`endif
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (RdAddrB == ADDR'(i)) begin
            rd_data_b_d = mem_q[i];
`ifdef REGFILE_PARITY_EN
            par_err_b_d = par_q[i] ^ (^mem_q[i]);
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
`ifdef REGFILE_PARITY_EN
        par_q[i] <= 1'b0;
`endif
      end
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
`ifdef REGFILE_PARITY_EN
      par_err_a_q  <= 1'b0;
      par_err_b_q  <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
`ifdef REGFILE_PARITY_EN
        par_q[i] <= par_d[i];
`endif
      end
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
`ifdef REGFILE_PARITY_EN
      par_err_a_q  <= par_err_a_d;
      par_err_b_q  <= par_err_b_d;
`endif
    end
  end

  assign RdDataA  = rd_data_a_q;
  assign RdValidA = rd_valid_a_q;
  assign RdDataB  = rd_data_b_q;
  assign RdValidB = rd_valid_b_q;
  assign Busy     = busy;
`ifdef REGFILE_PARITY_EN
  assign ParErrA  = par_err_a_q;
  assign ParErrB  = par_err_b_q;
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a DEPTH=8 and a DEPTH=6 instance share stimulus and are
// checked every cycle against a per-instance array model of the register file.
module tb_regfile_2r1w;

  logic        CLK = 1'b0;
  logic        RST;
  logic        wr_en, rd_en_a, rd_en_b, clr_req, par_inj;
  logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [15:0] wr_data;

  logic [15:0] rda [2];
  logic [15:0] rdb [2];
  logic        rva [2];
  logic        rvb [2];
  logic        bsy [2];
`ifdef REGFILE_PARITY_EN
  logic        pea [2];
  logic        peb [2];
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ADDR(3)) u_dut8 (
    .CLK(CLK), .RST(RST), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .RdEnA(rd_en_a), .RdAddrA(rd_addr_a), .RdDataA(rda[0]), .RdValidA(rva[0]),
    .RdEnB(rd_en_b), .RdAddrB(rd_addr_b), .RdDataB(rdb[0]), .RdValidB(rvb[0]),
    .ClrReq(clr_req), .Busy(bsy[0])
`ifdef REGFILE_PARITY_EN
    , .ParInj(par_inj), .ParErrA(pea[0]), .ParErrB(peb[0])
`endif
  );

  regfile_2r1w #(.WIDTH(16), .DEPTH(6), .ADDR(3)) u_dut6 (
    .CLK(CLK), .RST(RST), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .RdEnA(rd_en_a), .RdAddrA(rd_addr_a), .RdDataA(rda[1]), .RdValidA(rva[1]),
    .RdEnB(rd_en_b), .RdAddrB(rd_addr_b), .RdDataB(rdb[1]), .RdValidB(rvb[1]),
    .ClrReq(clr_req), .Busy(bsy[1])
`ifdef REGFILE_PARITY_EN
    , .ParInj(par_inj), .ParErrA(pea[1]), .ParErrB(peb[1])
`endif
  );

  // Reference model state: contents, injected-parity flags, remaining busy cycles.
  logic [15:0] mm  [2][8];
  logic        mc  [2][8];
  int          mcnt[2];
  int          msw [2];
  logic [15:0] eda [2];
  logic [15:0] edb [2];
  logic        eva [2];
  logic        evb [2];
  logic        epa [2];
  logic        epb [2];

  function automatic int dep(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        mm[k][i] = '0;
        mc[k][i] = 1'b0;
      end
      mcnt[k] = 0; msw[k] = 0;
      eda[k] = '0; edb[k] = '0;
      eva[k] = 1'b0; evb[k] = 1'b0; epa[k] = 1'b0; epb[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int  d;
      bit  hit;
      d = dep(k);
      if (mcnt[k] > 0) begin
        eva[k] = 1'b0; evb[k] = 1'b0; epa[k] = 1'b0; epb[k] = 1'b0;
        mm[k][msw[k]] = '0;
        mc[k][msw[k]] = 1'b0;
        msw[k]++;
        mcnt[k]--;
      end else begin
        hit = wr_en && (int'(wr_addr) < d);
        epa[k] = 1'b0; epb[k] = 1'b0;
        eva[k] = rd_en_a;
        if (rd_en_a) begin
          if (int'(rd_addr_a) >= d) eda[k] = '0;
          else if (hit && wr_addr == rd_addr_a) begin eda[k] = wr_data; epa[k] = par_inj; end
          else begin eda[k] = mm[k][rd_addr_a]; epa[k] = mc[k][rd_addr_a]; end
        end
        evb[k] = rd_en_b;
        if (rd_en_b) begin
          if (int'(rd_addr_b) >= d) edb[k] = '0;
          else if (hit && wr_addr == rd_addr_b) begin edb[k] = wr_data; epb[k] = par_inj; end
          else begin edb[k] = mm[k][rd_addr_b]; epb[k] = mc[k][rd_addr_b]; end
        end
        if (hit) begin
          mm[k][wr_addr] = wr_data;
          mc[k][wr_addr] = par_inj;
        end
        if (clr_req) begin
          mcnt[k] = d;
          msw[k]  = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_d%0d_rda", ph, dep(k)), 32'(rda[k]), 32'(eda[k]));
      chk($sformatf("%s_d%0d_rva", ph, dep(k)), 32'(rva[k]), 32'(eva[k]));
      chk($sformatf("%s_d%0d_rdb", ph, dep(k)), 32'(rdb[k]), 32'(edb[k]));
      chk($sformatf("%s_d%0d_rvb", ph, dep(k)), 32'(rvb[k]), 32'(evb[k]));
      chk($sformatf("%s_d%0d_busy", ph, dep(k)), 32'(bsy[k]), 32'(mcnt[k] > 0));
`ifdef REGFILE_PARITY_EN
      chk($sformatf("%s_d%0d_pea", ph, dep(k)), 32'(pea[k]), 32'(epa[k]));
      chk($sformatf("%s_d%0d_peb", ph, dep(k)), 32'(peb[k]), 32'(epb[k]));
`endif
    end
  endtask

  task automatic op(input string ph, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                    input logic rea, input logic [2:0] ra, input logic reb, input logic [2:0] rb,
                    input logic clr, input logic pinj);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en_a = rea; rd_addr_a = ra; rd_en_b = reb; rd_addr_b = rb;
    clr_req = clr; par_inj = pinj;
    @(posedge CLK);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic idle(input string ph);
    op(ph, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic fill(input string ph);
    for (int i = 0; i < 8; i++)
      op(ph, 1'b1, 3'(i), 16'($urandom), 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    RST = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_en_a = 0; rd_addr_a = 0;
    rd_en_b = 0; rd_addr_b = 0; clr_req = 0; par_inj = 0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Directed writes then dual read
    op("w3", 1'b1, 3'd3, 16'h000B, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    op("w7", 1'b1, 3'd7, 16'h0001, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    op("w1", 1'b1, 3'd1, 16'h001C, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    op("rd31", 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd1, 1'b0, 1'b0);
    chk("dual_rd_a", 32'(rda[0]), 32'h000B);
    chk("dual_rd_b", 32'(rdb[0]), 32'h001C);
    chk("dual_rd_va", 32'(rva[0]), 32'h1);
    chk("dual_rd_vb", 32'(rvb[0]), 32'h1);

    // Bypass and same address on both ports
    op("byp", 1'b1, 3'd5, 16'hBEEF, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0, 1'b0);
    chk("bypass_a", 32'(rda[0]), 32'hBEEF);
    chk("bypass_va", 32'(rva[0]), 32'h1);
    chk("bypass_b", 32'(rdb[0]), 32'hBEEF);
    idle("hold");
    chk("hold_data", 32'(rda[0]), 32'hBEEF);
    chk("hold_valid", 32'(rva[0]), 32'h0);

    // Out-of-range on the DEPTH=6 instance
    op("w6", 1'b1, 3'd6, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    op("r6", 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("oor_d6_data", 32'(rda[1]), 32'h0);
    chk("oor_d6_valid", 32'(rva[1]), 32'h1);
    chk("inr_d8_data", 32'(rda[0]), 32'h1234);
    for (int i = 0; i < 6; i += 2)
      op("oor_scan", 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(i + 1), 1'b0, 1'b0);

    // Random traffic
    for (int c = 0; c < 300; c++)
      op("rand", 1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom),
         1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom_range(0, 7)),
         ($urandom_range(0, 29) == 0), 1'($urandom));

    // Let any sweep in flight finish
    n = 0;
    while ((bsy[0] || bsy[1]) && n < 20) begin idle("drain"); n++; end
    chk("drain_bound", 32'(bsy[0] || bsy[1]), 32'h0);

    // Clear sweep: busy length and ignored writes
    fill("fill1");
    op("clr", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
    n = 0;
    while (bsy[0] && n < 20) begin
      n++;
      op("clr_wr", 1'b1, 3'd2, 16'h5555, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    end
    chk("busy_cycles", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      op("post_clr", 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b0, 3'd0, 1'b0, 1'b0);
      chk($sformatf("clr_zero_%0d", i), 32'(rda[0]), 32'h0);
    end

    // Reset in the middle of a sweep
    fill("fill2");
    op("clr2", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
    idle("sw1");
    idle("sw2");
    chk("sweep_busy", 32'(bsy[0]), 32'h1);
    RST = 1'b1;
    #1;
    model_reset();
    chk("rst_busy_now", 32'(bsy[0]), 32'h0);
    check_all("rst_mid");
    @(negedge CLK);
    RST = 1'b0;
    idle("after_rst");
    chk("after_rst_va", 32'(rva[0]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      op("rst_scan", 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(7 - i), 1'b0, 1'b0);
      chk($sformatf("rst_zero_%0d", i), 32'(rda[0] | rdb[0]), 32'h0);
    end

`ifdef REGFILE_PARITY_EN
    op("pinj", 1'b1, 3'd4, 16'h00FF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    op("prd1", 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("par_err_set", 32'(pea[0]), 32'h1);
    op("pfix", 1'b1, 3'd4, 16'h00FF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    op("prd2", 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("par_err_clr", 32'(pea[0]), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
